// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types, defaults and scan-classification helpers for
//               the 4x4 matrix keypad scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int c_scan_div_default = 100000;
    localparam int c_debounce_default = 5;

    // Debounce state machine encoding
    typedef enum logic [1:0] {
        ST_RELEASED   = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_RELEASE_DB = 2'd3
    } kp_state_t;

    // Result of one complete four-row scan
    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_res_t;

    // Classify a 16-bit pressed-key map (bit index = row*4 + col)
    function automatic scan_res_t classify(input logic [15:0] hits);
        scan_res_t res;
        if ($countones(hits) == 0) begin
            res = SCAN_NONE;
        end else if ($countones(hits) == 1) begin
            res = SCAN_SINGLE;
        end else begin
            res = SCAN_MULTI;
        end
        return res;
    endfunction

    // Index of the highest pressed key; only meaningful for a single hit
    function automatic logic [3:0] hit_index(input logic [15:0] hits);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hits[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : 4-bit two-flop synchronizer, resets to all ones (idle
//               level of pulled-up column lines).
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    // Two-stage capture of the asynchronous column inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 4'b1111;
            r_sync <= 4'b1111;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan
// Description : 4x4 matrix keypad scanner with full-scan debounce. Drives one
//               row low at a time, collects the synchronized columns into a
//               key map and runs a press/release debounce FSM once per scan.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = c_scan_div_default,
    parameter int DEBOUNCE = c_debounce_default
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_release
);

    localparam int               c_dwell_w    = $clog2(SCAN_DIV);
    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(SCAN_DIV - 1);
    localparam logic [3:0]       c_debounce   = 4'(DEBOUNCE);

    logic [c_dwell_w-1:0] r_dwell;
    logic [1:0]           r_row_idx;
    logic [3:0]           r_row;
    logic [11:0]          r_hits_lo;
    logic [3:0]           w_col_sync;
    logic                 w_dwell_end;
    logic                 w_scan_end;
    logic [15:0]          w_hits;
    scan_res_t            w_scan_res;
    logic [3:0]           w_hit_idx;

    kp_state_t            r_state,   w_state_nxt;
    logic [3:0]           r_cnt,     w_cnt_nxt;
    logic [3:0]           r_cand,    w_cand_nxt;
    logic [3:0]           r_code,    w_code_nxt;
    logic                 r_valid,   w_valid_nxt;
    logic                 r_held,    w_held_nxt;
    logic                 r_release, w_release_nxt;
    logic [3:0]           w_cnt_inc;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (col),
        .q     (w_col_sync)
    );

    assign w_dwell_end = (r_dwell == c_dwell_last);
    assign w_scan_end  = w_dwell_end && (r_row_idx == 2'd3);

    // Row 3 is evaluated directly from the synchronizer on its last cycle
    assign w_hits     = {~w_col_sync, r_hits_lo};
    assign w_scan_res = classify(w_hits);
    assign w_hit_idx  = hit_index(w_hits);
    assign w_cnt_inc  = r_cnt + 4'd1;

    // Row dwell counter and rotating one-cold row drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell   <= '0;
            r_row_idx <= 2'd0;
            r_row     <= 4'b1110;
        end else if (w_dwell_end) begin
            r_dwell   <= '0;
            r_row_idx <= r_row_idx + 2'd1;
            r_row     <= {r_row[2:0], r_row[3]};
        end else begin
            r_dwell   <= r_dwell + c_dwell_w'(1);
        end
    end

    // Latch the pressed columns of rows 0..2 at the end of their dwell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hits_lo <= '0;
        end else if (w_dwell_end) begin
            case (r_row_idx)
                2'd0:    r_hits_lo[3:0]  <= ~w_col_sync;
                2'd1:    r_hits_lo[7:4]  <= ~w_col_sync;
                2'd2:    r_hits_lo[11:8] <= ~w_col_sync;
                default: r_hits_lo       <= r_hits_lo;
            endcase
        end
    end

    // Debounce FSM and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RELEASED;
            r_cnt     <= 4'd0;
            r_cand    <= 4'd0;
            r_code    <= 4'd0;
            r_valid   <= 1'b0;
            r_held    <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cand    <= w_cand_nxt;
            r_code    <= w_code_nxt;
            r_valid   <= w_valid_nxt;
            r_held    <= w_held_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Next-state logic, evaluated only on the last cycle of a full scan
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cand_nxt    = r_cand;
        w_code_nxt    = r_code;
        w_held_nxt    = r_held;
        w_valid_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        if (w_scan_end) begin
            case (r_state)
                ST_RELEASED: begin
                    if (w_scan_res == SCAN_SINGLE) begin
                        w_cand_nxt  = w_hit_idx;
                        w_cnt_nxt   = 4'd1;
                        w_state_nxt = ST_PRESS_DB;
                    end
                end
                ST_PRESS_DB: begin
                    if (w_scan_res == SCAN_SINGLE && w_hit_idx == r_cand) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_debounce) begin
                            w_state_nxt = ST_PRESSED;
                            w_code_nxt  = r_cand;
                            w_held_nxt  = 1'b1;
                            w_valid_nxt = 1'b1;
                        end
                    end else if (w_scan_res == SCAN_SINGLE) begin
                        w_cand_nxt = w_hit_idx;
                        w_cnt_nxt  = 4'd1;
                    end else begin
                        w_state_nxt = ST_RELEASED;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                ST_PRESSED: begin
                    // Any key activity keeps the current press alive
                    if (w_scan_res == SCAN_NONE) begin
                        w_cnt_nxt   = 4'd1;
                        w_state_nxt = ST_RELEASE_DB;
                    end
                end
                ST_RELEASE_DB: begin
                    if (w_scan_res == SCAN_NONE) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_debounce) begin
                            w_state_nxt   = ST_RELEASED;
                            w_held_nxt    = 1'b0;
                            w_release_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    assign row         = r_row;
    assign key_code    = r_code;
    assign key_valid   = r_valid;
    assign key_held    = r_held;
    assign key_release = r_release;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan
// Description : Self-checking bench for keypad_scan with a key-matrix model
//               (SCAN_DIV=8, DEBOUNCE=3, one scan = 32 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

    localparam int c_scan = 32;

    logic        clk;
    logic        rst_n;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        key_release;
    logic [15:0] pressed;

    int checks    = 0;
    int errors    = 0;
    int valid_cnt = 0;
    int rel_cnt   = 0;

    keypad_scan #(
        .SCAN_DIV (8),
        .DEBOUNCE (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .col         (col),
        .row         (row),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .key_release (key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: a pressed key shorts its row line onto its column line
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Per-cycle protocol monitor: pulse/level pairing and row sequencing
    logic [3:0] prev_row  = 4'b1110;
    logic       prev_held = 1'b0;
    int         run_len   = 0;
    bit         fresh     = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            fresh     = 1'b1;
            run_len   = 0;
            prev_held = key_held;
            prev_row  = row;
        end else begin
            if (key_valid) begin
                valid_cnt++;
                chk("valid_pairing", {key_held, prev_held, key_release}, 3'b100);
            end
            if (key_release) begin
                rel_cnt++;
                chk("release_pairing", {key_held, prev_held, key_valid}, 3'b010);
            end
            if (key_held != prev_held) chk("held_edge_pulse", key_valid | key_release, 1);
            if (row != prev_row) begin
                if (!fresh) begin
                    chk("row_dwell", run_len, 8);
                    chk("row_order", row, {prev_row[2:0], prev_row[3]});
                end
                fresh   = 1'b0;
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_held = key_held;
            prev_row  = row;
        end
    end

    // Move to scan offset 3 (fourth cycle of row 0)
    task automatic align();
        logic [3:0] prv;
        bit         found;
        prv   = row;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (row == 4'b1110 && prv == 4'b0111) begin
                found = 1'b1;
                break;
            end
            prv = row;
        end
        chk("align_found", found, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_valid(input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (key_valid) begin
                k = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [15:0] keys;
        int          scans;
        int          exp_valid;
        int          exp_rel;
        int          exp_code;
        int          exp_held;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, v0, r0, first;

        vecs[0]  = '{16'h0040, 3, 1, 0,  6, 1};
        vecs[1]  = '{16'h0000, 1, 0, 0,  6, 1};
        vecs[2]  = '{16'h0040, 2, 0, 0,  6, 1};
        vecs[3]  = '{16'h0000, 3, 0, 1,  6, 0};
        vecs[4]  = '{16'h8001, 4, 0, 0,  6, 0};
        vecs[5]  = '{16'h0001, 3, 1, 0,  0, 1};
        vecs[6]  = '{16'h8001, 2, 0, 0,  0, 1};
        vecs[7]  = '{16'h0200, 2, 0, 0,  0, 1};
        vecs[8]  = '{16'h0000, 3, 0, 1,  0, 0};
        vecs[9]  = '{16'h0200, 3, 1, 0,  9, 1};
        vecs[10] = '{16'h0000, 3, 0, 1,  9, 0};
        vecs[11] = '{16'h0020, 2, 0, 0,  9, 0};
        vecs[12] = '{16'h0000, 1, 0, 0,  9, 0};
        vecs[13] = '{16'h0020, 2, 0, 0,  9, 0};
        vecs[14] = '{16'h0008, 2, 0, 0,  9, 0};
        vecs[15] = '{16'h1000, 3, 1, 0, 12, 1};
        vecs[16] = '{16'h0000, 3, 0, 1, 12, 0};

        rst_n   = 1'b0;
        pressed = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_row", row, 4'b1110);
        chk("rst_code", key_code, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_held", key_held, 0);
        chk("rst_release", key_release, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // First-press latency: key 6 held from scan offset 3
        align();
        pressed = 16'h0040;
        wait_valid(200, k);
        chk_range("latency_scan_cycle", k + 3, 96, 98);
        chk("latency_code", key_code, 6);
        chk("latency_held", key_held, 1);
        pressed = 16'h0000;
        repeat (4 * c_scan) @(negedge clk);
        #1 chk("latency_released", key_held, 0);

        // Table of scan-aligned key patterns
        align();
        for (int i = 0; i < 17; i++) begin
            v0      = valid_cnt;
            r0      = rel_cnt;
            pressed = vecs[i].keys;
            repeat (vecs[i].scans * c_scan) @(negedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
            chk($sformatf("vec%0d_release", i), rel_cnt - r0, vecs[i].exp_rel);
            chk($sformatf("vec%0d_code", i), key_code, vecs[i].exp_code);
            chk($sformatf("vec%0d_held", i), key_held, vecs[i].exp_held);
        end

        // Bounce on key 6: toggles every 20 cycles for 200 cycles
        repeat (21) @(negedge clk);
        v0 = valid_cnt;
        for (int m = 0; m < 10; m++) begin
            pressed = (m % 2 == 0) ? 16'h0040 : 16'h0000;
            repeat (20) @(negedge clk);
        end
        chk("bounce_quiet", valid_cnt - v0, 0);
        pressed = 16'h0040;
        first   = -1;
        for (int j = 1; j <= 160; j++) begin
            @(negedge clk);
            if (key_valid && first < 0) first = 200 + j;
        end
        #1;
        chk_range("bounce_accept_time", first, 293, 299);
        chk("bounce_single_pulse", valid_cnt - v0, 1);
        chk("bounce_code", key_code, 6);
        pressed = 16'h0000;
        repeat (4 * c_scan) @(negedge clk);

        // Reset during PRESS_DB with key still held
        align();
        pressed = 16'h0040;
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstdb_row", row, 4'b1110);
        chk("rstdb_code", key_code, 0);
        chk("rstdb_held", key_held, 0);
        chk("rstdb_valid", key_valid, 0);
        v0 = valid_cnt;
        r0 = rel_cnt;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_valid(130, k);
        #1;
        chk_range("rstdb_reaccept", k, 94, 98);
        chk("rstdb_one_pulse", valid_cnt - v0, 1);
        chk("rstdb_code_after", key_code, 6);

        // Reset while PRESSED
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstpr_row", row, 4'b1110);
        chk("rstpr_code", key_code, 0);
        chk("rstpr_held", key_held, 0);
        chk("rstpr_release", key_release, 0);
        v0 = valid_cnt;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_valid(130, k);
        #1;
        chk_range("rstpr_reaccept", k, 94, 98);
        chk("rstpr_no_release", rel_cnt - r0, 0);
        chk("rstpr_one_pulse", valid_cnt - v0, 1);
        chk("rstpr_code_after", key_code, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
